// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a req/ack handshake with fixed access latency.
// Flags misaligned or out-of-range accesses and stalls the MEM stage until ack.
module dmem_responder #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ready_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        stall_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_next;
  logic            r_we;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_ready;
  logic            r_ack;
  logic            r_err;
  logic [31:0]     r_mem [DEPTH];

  logic            w_accept;
  logic            w_commit;
  logic            w_err;
  logic            w_we;
  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [AW-1:0]   w_idx;

  // Next-state and down-counter
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          w_accept = 1'b1;
          if (LATENCY == 1) begin
            w_next = RESP;
          end else begin
            w_next     = WAIT;
            w_cnt_next = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) w_next = RESP;
        else             w_cnt_next = r_cnt - CW'(1);
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // With LATENCY=1 the commit edge is also the capture edge, so use the live inputs then
  assign w_we     = (r_state == IDLE) ? we_i    : r_we;
  assign w_addr   = (r_state == IDLE) ? addr_i  : r_addr;
  assign w_wdata  = (r_state == IDLE) ? wdata_i : r_wdata;
  assign w_idx    = w_addr[AW+1:2];
  assign w_err    = (w_addr[1:0] != 2'b00) || (w_addr[31:2] >= 30'(DEPTH));
  assign w_commit = (r_state != RESP) && (w_next == RESP);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ready <= 1'b1;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_ready <= (w_next == IDLE);
      r_ack   <= (w_next == RESP);
      if (w_accept) begin
        r_we    <= we_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end
      if (w_commit) begin
        r_err <= w_err;
        if (!w_we) r_rdata <= w_err ? 32'h0 : r_mem[w_idx];
      end else if (r_state == RESP) begin
        r_err <= 1'b0;
      end
    end
  end

  // Storage is not reset; writes are blocked while reset is held
  always_ff @(posedge clk_i) begin
    if (w_commit && w_we && !w_err && rst_i) r_mem[w_idx] <= w_wdata;
  end

  assign ready_o = r_ready;
  assign ack_o   = r_ack;
  assign rdata_o = r_rdata;
  assign err_o   = r_err;
  assign stall_o = req_i & ~r_ack;

endmodule
